// File: rtl/mult_issue_queue.sv
// In-order request queue between issue and the mult unit.
// MUL-class heads dispatch at once; DIV-class heads wait for the divider's ready.
package config_pkg;
    typedef struct packed {
        logic [31:0] XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd64};
endpackage

package mult_issue_queue_pkg;
    typedef enum logic [7:0] {
        ADD, SUB, ANDL, ORL, XORL,
        MUL, MULH, MULHU, MULHSU, MULW, CLMUL, CLMULH, CLMULR,
        DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW
    } fu_op;

    typedef struct packed {
        fu_op        operation;
        logic [63:0] operand_a;
        logic [63:0] operand_b;
        logic [2:0]  trans_id;
        logic        thread_id;
    } fu_data_t;
endpackage

module mult_issue_queue #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_empty,
    parameter type                   fu_data_t = mult_issue_queue_pkg::fu_data_t,
    parameter int unsigned           DEPTH     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  fu_data_t                     fu_data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output fu_data_t                     fu_data_o,
    output logic                         mult_valid_o,
    input  logic                         mult_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         illegal_o
);
    import mult_issue_queue_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        CLS_MUL,
        CLS_DIV,
        CLS_ILLEGAL
    } op_class_e;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CVA6Cfg.XLEN == 0) begin : gen_cfg_check
        $error("mult_issue_queue: DEPTH must be a power of two >= 2");
    end

    fu_data_t      mem_q [DEPTH];
    fu_data_t      mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    fu_data_t      head;
    op_class_e     head_cls;
    logic          push;
    logic          pop;

    always_comb begin
        head = mem_q[rd_ptr_q];
        case (head.operation)
            MUL, MULH, MULHU, MULHSU, MULW, CLMUL, CLMULH, CLMULR: head_cls = CLS_MUL;
            DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW:       head_cls = CLS_DIV;
            default:                                              head_cls = CLS_ILLEGAL;
        endcase
    end

    // ready_o comes only from the registered count, so a full queue never
    // accepts in the cycle it pops.
    always_comb begin
        ready_o      = (count_q < CW'(DEPTH));
        count_o      = count_q;
        fu_data_o    = head;
        mult_valid_o = 1'b0;
        illegal_o    = 1'b0;
        if (count_q != '0 && !flush_i) begin
            case (head_cls)
                CLS_MUL: mult_valid_o = 1'b1;
                CLS_DIV: mult_valid_o = mult_ready_i;
                default: illegal_o    = 1'b1;
            endcase
        end
        push = valid_i & ready_o & ~flush_i;
        pop  = mult_valid_o | illegal_o;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = fu_data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_mult_issue_queue.sv
// Scenario bench for mult_issue_queue: a scoreboard queue holds the expected
// entries in push order and is popped whenever a dispatch or drop is due.
module tb_mult_issue_queue;
    import mult_issue_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       flush_i = 1'b0;
    fu_data_t   fu_data_i = '0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    fu_data_t   fu_data_o;
    logic       mult_valid_o;
    logic       mult_ready_i = 1'b0;
    logic [2:0] count_o;
    logic       illegal_o;

    int checks = 0;
    int errors = 0;

    fu_data_t sb[$];
    logic     exp_ready, exp_valid, exp_illegal, exp_accept, cur_flush;
    int       exp_count;
    fu_data_t exp_head;

    always #5 clk = ~clk;

    mult_issue_queue #(
        .CVA6Cfg  (config_pkg::cva6_cfg_empty),
        .fu_data_t(fu_data_t),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .fu_data_i   (fu_data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .fu_data_o   (fu_data_o),
        .mult_valid_o(mult_valid_o),
        .mult_ready_i(mult_ready_i),
        .count_o     (count_o),
        .illegal_o   (illegal_o)
    );

    function automatic fu_data_t mk(input fu_op op, input int tid, input logic th);
        fu_data_t d;
        d.operation = op;
        d.operand_a = {$urandom, $urandom};
        d.operand_b = {$urandom, $urandom};
        d.trans_id  = 3'(tid);
        d.thread_id = th;
        return d;
    endfunction

    function automatic int op_class(input fu_op op);
        if (op inside {MUL, MULH, MULHU, MULHSU, MULW, CLMUL, CLMULH, CLMULR}) return 0;
        if (op inside {DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW}) return 1;
        return 2;
    endfunction

    // Called just after a falling edge: applies inputs, then derives the
    // expected outputs for this cycle from the scoreboard.
    task automatic drive(input logic v, input fu_data_t d, input logic mr, input logic fl);
        valid_i      = v;
        fu_data_i    = d;
        mult_ready_i = mr;
        flush_i      = fl;
        cur_flush    = fl;
        #1;
        exp_count   = sb.size();
        exp_ready   = (sb.size() < DEPTH);
        exp_head    = (sb.size() != 0) ? sb[0] : '0;
        exp_valid   = 1'b0;
        exp_illegal = 1'b0;
        if (sb.size() != 0 && !fl) begin
            case (op_class(exp_head.operation))
                0:       exp_valid   = 1'b1;
                1:       exp_valid   = mr;
                default: exp_illegal = 1'b1;
            endcase
        end
        exp_accept = v && exp_ready && !fl;
    endtask

    task automatic retire();
        if (cur_flush) begin
            sb.delete();
        end else begin
            if (exp_valid || exp_illegal) void'(sb.pop_front());
            if (exp_accept) sb.push_back(fu_data_i);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        checks++; if (mult_valid_o !== 1'b0 || illegal_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got valid=%b illegal=%b expected 0/0", mult_valid_o, illegal_o); end
        checks++; if (fu_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", fu_data_o); end
        @(negedge clk);
        rst_ni = 1'b1;
        sb.delete();
    endtask

    task automatic test_single_mul();
        fu_data_t d = mk(MUL, 3, 1'b1);
        drive(1'b1, d, 1'b0, 1'b0);
        checks++; if (mult_valid_o !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b expected 0", mult_valid_o); end
        retire();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL single_count1: got %0d expected 1", count_o); end
        checks++; if (mult_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", mult_valid_o); end
        checks++; if (fu_data_o !== d || fu_data_o.trans_id !== 3'd3 || fu_data_o.thread_id !== 1'b1) begin
            errors++; $display("FAIL single_data: got tid=%0d thr=%0d expected tid=3 thr=1", fu_data_o.trans_id, fu_data_o.thread_id);
        end
        retire();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (count_o !== 3'd0 || mult_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain: got count=%0d valid=%b expected 0/0", count_o, mult_valid_o); end
        retire();
    endtask

    task automatic test_div_fill();
        drive(1'b1, mk(DIV, 0, 1'b0), 1'b0, 1'b0);
        retire();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, mk(MUL, i, 1'b0), 1'b0, 1'b0);
            checks++; if (mult_valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL fill_%0d: got valid=%b ready=%b expected 0/1", i, mult_valid_o, ready_o); end
            retire();
        end
        drive(1'b1, mk(MUL, 4, 1'b0), 1'b0, 1'b0);
        checks++; if (count_o !== 3'd4 || ready_o !== 1'b0 || mult_valid_o !== 1'b0) begin
            errors++; $display("FAIL fill_full: got count=%0d ready=%b valid=%b expected 4/0/0", count_o, ready_o, mult_valid_o);
        end
        retire();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (mult_valid_o !== 1'b1 || fu_data_o.trans_id !== 3'(k)) begin
                errors++; $display("FAIL drain_%0d: got valid=%b tid=%0d expected 1/%0d", k, mult_valid_o, fu_data_o.trans_id, k);
            end
            checks++; if (fu_data_o !== exp_head) begin errors++; $display("FAIL drain_sb_%0d: got %h expected %h", k, fu_data_o, exp_head); end
            retire();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (count_o !== 3'd0 || mult_valid_o !== 1'b0) begin errors++; $display("FAIL fill_empty: got count=%0d valid=%b expected 0/0", count_o, mult_valid_o); end
        retire();
    endtask

    task automatic test_back_to_back();
        int disp = 0;
        for (int i = 0; i <= 20; i++) begin
            drive(i < 20, mk(MULW, i % 8, 1'(i)), 1'b0, 1'b0);
            checks++; if (ready_o !== 1'b1 || count_o !== 3'((i == 0) ? 0 : 1)) begin
                errors++; $display("FAIL b2b_ready_%0d: got ready=%b count=%0d expected 1/%0d", i, ready_o, count_o, (i == 0) ? 0 : 1);
            end
            checks++; if (mult_valid_o !== (i != 0)) begin errors++; $display("FAIL b2b_valid_%0d: got %b expected %b", i, mult_valid_o, i != 0); end
            if (mult_valid_o === 1'b1) begin
                disp++;
                checks++; if (fu_data_o !== exp_head) begin errors++; $display("FAIL b2b_order_%0d: got tid=%0d expected tid=%0d", i, fu_data_o.trans_id, exp_head.trans_id); end
            end
            retire();
        end
        checks++; if (disp != 20) begin errors++; $display("FAIL b2b_dispatches: got %0d expected 20", disp); end
    endtask

    task automatic test_flush();
        drive(1'b1, mk(DIVU, 7, 1'b0), 1'b0, 1'b0); retire();
        drive(1'b1, mk(MUL, 1, 1'b0), 1'b0, 1'b0);  retire();
        drive(1'b1, mk(MUL, 2, 1'b0), 1'b0, 1'b0);  retire();
        drive(1'b1, mk(MUL, 3, 1'b0), 1'b1, 1'b1);
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", count_o); end
        checks++; if (mult_valid_o !== 1'b0 || illegal_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got valid=%b illegal=%b expected 0/0", mult_valid_o, illegal_o); end
        retire();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (count_o !== 3'd0 || mult_valid_o !== 1'b0) begin errors++; $display("FAIL flush_after_%0d: got count=%0d valid=%b expected 0/0", i, count_o, mult_valid_o); end
            retire();
        end
    endtask

    task automatic test_illegal();
        fu_data_t seq [3];
        int nvalid = 0;
        int nill = 0;
        seq[0] = mk(MULHU, 1, 1'b0);
        seq[1] = mk(ADD, 2, 1'b0);
        seq[2] = mk(CLMUL, 3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(i < 3, (i < 3) ? seq[i] : '0, 1'b0, 1'b0);
            checks++; if (mult_valid_o !== exp_valid || illegal_o !== exp_illegal) begin
                errors++; $display("FAIL illegal_cyc_%0d: got valid=%b illegal=%b expected %b/%b", i, mult_valid_o, illegal_o, exp_valid, exp_illegal);
            end
            if (mult_valid_o === 1'b1) begin
                nvalid++;
                checks++; if (fu_data_o !== exp_head) begin errors++; $display("FAIL illegal_data_%0d: got tid=%0d expected tid=%0d", i, fu_data_o.trans_id, exp_head.trans_id); end
            end
            if (illegal_o === 1'b1) nill++;
            retire();
        end
        checks++; if (nvalid != 2 || nill != 1) begin errors++; $display("FAIL illegal_counts: got valid=%0d illegal=%0d expected 2/1", nvalid, nill); end
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL illegal_count_end: got %0d expected 0", count_o); end
        retire();
    endtask

    task automatic test_async_reset();
        drive(1'b1, mk(REM, 5, 1'b0), 1'b0, 1'b0); retire();
        drive(1'b1, mk(MUL, 6, 1'b0), 1'b0, 1'b0); retire();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (mult_valid_o !== 1'b1 || count_o !== 3'd2) begin errors++; $display("FAIL areset_pre: got valid=%b count=%0d expected 1/2", mult_valid_o, count_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (mult_valid_o !== 1'b0 || count_o !== 3'd0 || ready_o !== 1'b1 || illegal_o !== 1'b0) begin
            errors++; $display("FAIL areset_now: got valid=%b count=%0d ready=%b illegal=%b expected 0/0/1/0", mult_valid_o, count_o, ready_o, illegal_o);
        end
        checks++; if (fu_data_o !== '0) begin errors++; $display("FAIL areset_data: got %h expected 0", fu_data_o); end
        @(negedge clk);
        rst_ni = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (mult_valid_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL areset_after_%0d: got valid=%b count=%0d expected 0/0", i, mult_valid_o, count_o); end
            retire();
        end
    endtask

    initial begin
        test_reset();
        test_single_mul();
        test_div_fill();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
